// File: rtl/cache_fill_ctrl.sv
// Miss handler and memory-port owner: serialises I/D block fills and D-side
// write-through stores onto a single pipelined memory port.
module cache_fill_ctrl #(
  parameter int unsigned MEM_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_miss,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss,
  input  logic [15:0] d_miss_addr,
  input  logic        d_wr_req,
  input  logic [15:0] d_wr_addr,
  input  logic [15:0] d_wr_data,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_word,
  output logic        i_fill_we,
  output logic        d_fill_we,
  output logic        i_tag_we,
  output logic        d_tag_we,
  output logic        i_fill_done,
  output logic        d_fill_done,
  output logic        d_wr_done,
  output logic        busy
);

  localparam int unsigned WORDS = 8;
  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 16;
  localparam int unsigned WW    = $clog2(WORDS);
  localparam int unsigned IW    = WW + 1;
  localparam int unsigned LW    = $clog2(MEM_LATENCY + 1);
  localparam logic [AW-1:0] BLOCK_MASK = ~AW'(2 * WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    FILL
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   issue_q, issue_d;
  logic [WW-1:0]   recv_q, recv_d;
  logic [LW-1:0]   drain_q, drain_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            tgt_is_d_q, tgt_is_d_d;
  logic [AW-1:0]   base;

  assign base      = addr_q & BLOCK_MASK;
  assign fill_data = mem_rdata;

  // Reset starts a drain window that swallows returns of pre-reset reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      issue_q    <= '0;
      recv_q     <= '0;
      drain_q    <= LW'(MEM_LATENCY);
      addr_q     <= '0;
      wdata_q    <= '0;
      tgt_is_d_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      issue_q    <= issue_d;
      recv_q     <= recv_d;
      drain_q    <= drain_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      tgt_is_d_q <= tgt_is_d_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    issue_d     = issue_q;
    recv_d      = recv_q;
    drain_d     = drain_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    tgt_is_d_d  = tgt_is_d_q;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    fill_word   = recv_q;
    i_fill_we   = 1'b0;
    d_fill_we   = 1'b0;
    i_tag_we    = 1'b0;
    d_tag_we    = 1'b0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    d_wr_done   = 1'b0;
    busy        = (state_q != IDLE) || (drain_q != '0);

    case (state_q)
      IDLE: begin
        // Stores first so write-through data never waits behind a fill.
        if (drain_q != '0) begin
          drain_d = drain_q - 1'b1;
        end else if (d_wr_req) begin
          state_d = WRITE;
          addr_d  = d_wr_addr;
          wdata_d = d_wr_data;
          issue_d = '0;
          recv_d  = '0;
        end else if (d_miss) begin
          state_d    = FILL;
          addr_d     = d_miss_addr;
          tgt_is_d_d = 1'b1;
          issue_d    = '0;
          recv_d     = '0;
        end else if (i_miss) begin
          state_d    = FILL;
          addr_d     = i_miss_addr;
          tgt_is_d_d = 1'b0;
          issue_d    = '0;
          recv_d     = '0;
        end
      end

      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        d_wr_done = 1'b1;
        state_d   = IDLE;
      end

      FILL: begin
        if (issue_q < IW'(WORDS)) begin
          mem_en   = 1'b1;
          mem_addr = base + AW'({issue_q[WW-1:0], 1'b0});
          issue_d  = issue_q + 1'b1;
        end
        // Returns arrive in issue order, so recv_q is the halfword offset.
        if (mem_rvalid) begin
          i_fill_we = !tgt_is_d_q;
          d_fill_we = tgt_is_d_q;
          recv_d    = recv_q + 1'b1;
          if (recv_q == WW'(WORDS - 1)) begin
            i_tag_we    = !tgt_is_d_q;
            d_tag_we    = tgt_is_d_q;
            i_fill_done = !tgt_is_d_q;
            d_fill_done = tgt_is_d_q;
            state_d     = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Self-checking bench for cache_fill_ctrl: pipelined memory model, request
// generator and a transaction-level reference model checked every cycle.
module tb_cache_fill_ctrl;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss, d_miss, d_wr_req;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic        mem_en, mem_wr, mem_rvalid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
  logic [2:0]  fill_word;
  logic        i_fill_we, d_fill_we, i_tag_we, d_tag_we;
  logic        i_fill_done, d_fill_done, d_wr_done, busy;

  always #5 clk = ~clk;

  cache_fill_ctrl #(.MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .fill_data(fill_data), .fill_word(fill_word),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_tag_we(i_tag_we), .d_tag_we(d_tag_we),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
    .d_wr_done(d_wr_done), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: 0 = no operation, 1 = store, 2 = block fill.
  int          m_op = 0, m_k = 0, m_recv = 0, m_drain = LAT;
  bit          m_tgt_d = 0;
  logic [15:0] m_base = '0, m_waddr = '0, m_wdata = '0;

  typedef struct {
    int          due;
    logic [15:0] data;
  } ret_t;
  ret_t rq[$];

  bit          d_done_flag = 0, i_done_flag = 0, wr_done_flag = 0, inj = 0;
  int          d_we_n, i_we_n, d_tag_n, i_tag_n, d_done_n, i_done_n;
  int          d_done_cyc, i_done_cyc, wr_done_cyc;
  logic [15:0] rd_log[$];
  int          fw_log[$];
  logic [15:0] wr_addr_seen, wr_data_seen, d_last_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    d_we_n = 0; i_we_n = 0; d_tag_n = 0; i_tag_n = 0; d_done_n = 0; i_done_n = 0;
    d_done_cyc = -1; i_done_cyc = -1; wr_done_cyc = -1;
    rd_log.delete(); fw_log.delete();
    wr_addr_seen = '0; wr_data_seen = '0; d_last_data = '0;
  endtask

  // Advance the model across the coming clock edge using the inputs it samples.
  task automatic model_update();
    if (rst) begin
      m_op = 0; m_drain = LAT; m_k = 0; m_recv = 0;
    end else if (m_op == 1) begin
      m_op = 0;
    end else if (m_op == 2) begin
      m_k++;
      if (mem_rvalid) begin
        if (m_recv == 7) m_op = 0;
        m_recv++;
      end
    end else if (m_drain > 0) begin
      m_drain--;
    end else if (d_wr_req) begin
      m_op = 1; m_waddr = d_wr_addr; m_wdata = d_wr_data;
    end else if (d_miss) begin
      m_op = 2; m_tgt_d = 1; m_base = d_miss_addr & 16'hFFF0; m_k = 0; m_recv = 0;
    end else if (i_miss) begin
      m_op = 2; m_tgt_d = 0; m_base = i_miss_addr & 16'hFFF0; m_k = 0; m_recv = 0;
    end
  endtask

  task automatic check();
    bit en_e, v, last;
    en_e = (m_op == 1) || (m_op == 2 && m_k < 8);
    v    = (m_op == 2) && mem_rvalid;
    last = v && (m_recv == 7);
    chk("busy", busy, (m_op != 0 || m_drain > 0));
    chk("mem_en", mem_en, en_e);
    if (en_e) begin
      chk("mem_wr", mem_wr, (m_op == 1));
      chk("mem_addr", mem_addr, (m_op == 1) ? 32'(m_waddr) : 32'(int'(m_base) + 2 * m_k));
      if (m_op == 1) chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("d_wr_done", d_wr_done, (m_op == 1));
    chk("i_fill_we", i_fill_we, v && !m_tgt_d);
    chk("d_fill_we", d_fill_we, v && m_tgt_d);
    chk("i_tag_we", i_tag_we, last && !m_tgt_d);
    chk("d_tag_we", d_tag_we, last && m_tgt_d);
    chk("i_fill_done", i_fill_done, last && !m_tgt_d);
    chk("d_fill_done", d_fill_done, last && m_tgt_d);
    if (v) begin
      chk("fill_word", fill_word, m_recv);
      chk("fill_data", fill_data, mem_rdata);
    end
    // Environment bookkeeping driven by what the DUT actually did.
    if (mem_en && !mem_wr) begin
      rq.push_back('{due: cyc + LAT, data: mem_addr ^ 16'hA5A5});
      rd_log.push_back(mem_addr);
    end
    if (mem_en && mem_wr) begin wr_addr_seen = mem_addr; wr_data_seen = mem_wdata; end
    if (d_fill_we) begin d_we_n++; fw_log.push_back(int'(fill_word)); d_last_data = fill_data; end
    if (i_fill_we) begin i_we_n++; fw_log.push_back(int'(fill_word)); end
    if (d_tag_we) d_tag_n++;
    if (i_tag_we) i_tag_n++;
    if (d_fill_done) begin d_done_n++; d_done_cyc = cyc; d_done_flag = 1; end
    if (i_fill_done) begin i_done_n++; i_done_cyc = cyc; i_done_flag = 1; end
    if (d_wr_done) begin wr_done_cyc = cyc; wr_done_flag = 1; end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    cyc++;
    #1;
    if (d_done_flag)  begin d_miss = 0;   d_done_flag = 0;  end
    if (i_done_flag)  begin i_miss = 0;   i_done_flag = 0;  end
    if (wr_done_flag) begin d_wr_req = 0; wr_done_flag = 0; end
    mem_rvalid = 1'b0;
    mem_rdata  = 16'($urandom);
    if (rq.size() > 0 && rq[0].due == cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rq[0].data;
      rq.delete(0);
    end else if (inj && m_op == 0) begin
      mem_rvalid = 1'b1;
    end
    @(negedge clk);
    check();
  endtask

  task automatic wait_d(input int n0, input int lim);
    int n = 0;
    while (d_done_n <= n0 && n < lim) begin tick(); n++; end
    if (d_done_n <= n0) chk("d_fill_done timeout", 0, 1);
  endtask

  task automatic wait_i(input int n0, input int lim);
    int n = 0;
    while (i_done_n <= n0 && n < lim) begin tick(); n++; end
    if (i_done_n <= n0) chk("i_fill_done timeout", 0, 1);
  endtask

  initial begin
    int t, c0, rel, busy_n, n;
    bit stop;
    rst = 1; i_miss = 0; d_miss = 0; d_wr_req = 0;
    i_miss_addr = '0; d_miss_addr = '0; d_wr_addr = '0; d_wr_data = '0;
    mem_rvalid = 0; mem_rdata = '0;
    clear_stats();

    // Reset, drain length, first request held through drain.
    tick(); tick();
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst fill_word", fill_word, 0);
    chk("rst busy", busy, 1);
    rel = cyc;
    rst = 0; d_miss = 1; d_miss_addr = 16'h1236;
    busy_n = 1; stop = 0;
    for (int i = 0; i < 10 && !stop; i++) begin
      tick();
      if (busy) busy_n++; else stop = 1;
    end
    chk("drain busy cycles", busy_n, 4);
    wait_d(0, 40);
    chk("d first addr", rd_log.size() > 0 ? 32'(rd_log[0]) : 32'hDEAD, 16'h1230);
    chk("d last addr", rd_log.size() > 7 ? 32'(rd_log[7]) : 32'hDEAD, 16'h123E);
    chk("d read count", rd_log.size(), 8);
    chk("d done latency", d_done_cyc - rel, 16);
    chk("d fill_we count", d_we_n, 8);
    chk("d tag_we count", d_tag_n, 1);
    chk("i activity", i_we_n + i_tag_n + i_done_n, 0);
    chk("d word7 data", d_last_data, 16'hB79B);
    chk("d word7 index", fw_log.size() > 7 ? fw_log[7] : -1, 7);

    // Store with a concurrent I miss.
    tick(); tick(); tick();
    clear_stats();
    d_wr_req = 1; d_wr_addr = 16'h0040; d_wr_data = 16'hBEEF;
    i_miss = 1; i_miss_addr = 16'h0208;
    t = cyc;
    wait_i(0, 40);
    chk("wr done latency", wr_done_cyc - t, 1);
    chk("wr addr", wr_addr_seen, 16'h0040);
    chk("wr data", wr_data_seen, 16'hBEEF);
    chk("i done latency", i_done_cyc - t, 14);
    chk("i first addr", rd_log.size() > 0 ? 32'(rd_log[0]) : 32'hDEAD, 16'h0200);
    chk("i fill_we count", i_we_n, 8);

    // Simultaneous D and I misses, I block at the top of memory.
    tick(); tick();
    clear_stats();
    d_miss = 1; d_miss_addr = 16'h3458;
    i_miss = 1; i_miss_addr = 16'hFFF7;
    t = cyc;
    wait_i(0, 60);
    chk("dual d done", d_done_cyc - t, 12);
    chk("dual i done", i_done_cyc - t, 25);
    chk("dual d base", rd_log.size() > 0 ? 32'(rd_log[0]) : 32'hDEAD, 16'h3450);
    chk("dual i base", rd_log.size() > 8 ? 32'(rd_log[8]) : 32'hDEAD, 16'hFFF0);
    chk("dual i top", rd_log.size() > 15 ? 32'(rd_log[15]) : 32'hDEAD, 16'hFFFE);
    chk("dual reads", rd_log.size(), 16);

    // Spurious returns while idle.
    tick();
    clear_stats();
    inj = 1;
    repeat (4) tick();
    inj = 0;
    chk("spurious fill_we", i_we_n + d_we_n, 0);
    d_miss = 1; d_miss_addr = 16'h0800;
    t = cyc;
    wait_d(0, 40);
    chk("post-spurious words", fw_log.size(), 8);
    chk("post-spurious word0", fw_log.size() > 0 ? fw_log[0] : -1, 0);
    chk("post-spurious word7", fw_log.size() > 7 ? fw_log[7] : -1, 7);
    chk("post-spurious done", d_done_cyc - t, 12);

    // Reset after three returns of a D fill; request stays held.
    tick(); tick();
    clear_stats();
    d_miss = 1; d_miss_addr = 16'h2000;
    n = 0;
    while (d_we_n < 3 && n < 30) begin tick(); n++; end
    if (d_we_n < 3) chk("3 returns timeout", 0, 1);
    c0 = cyc;
    rst = 1;
    tick();
    rst = 0;
    wait_d(0, 60);
    chk("rst fill_we total", d_we_n, 11);
    chk("rst tag_we total", d_tag_n, 1);
    chk("rst done total", d_done_n, 1);
    chk("rst done latency", d_done_cyc - c0, 17);
    chk("rst restart word", fw_log.size() > 3 ? fw_log[3] : -1, 0);
    chk("rst reads", rd_log.size(), 15);
    chk("rst restart addr", rd_log.size() > 7 ? 32'(rd_log[7]) : 32'hDEAD, 16'h2000);

    // Randomised traffic with occasional resets and spurious returns.
    tick();
    clear_stats();
    for (int i = 0; i < 3000; i++) begin
      if (!d_wr_req && $urandom_range(0, 15) == 0) begin
        d_wr_req = 1; d_wr_addr = 16'($urandom); d_wr_data = 16'($urandom);
      end
      if (!d_miss && $urandom_range(0, 19) == 0) begin
        d_miss = 1; d_miss_addr = 16'($urandom);
      end
      if (!i_miss && $urandom_range(0, 19) == 0) begin
        i_miss = 1; i_miss_addr = 16'($urandom);
      end
      inj = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 0; inj = 0;
    n = 0;
    while ((d_miss || i_miss || d_wr_req || busy) && n < 300) begin tick(); n++; end
    chk("random quiesce", (d_miss || i_miss || d_wr_req || busy), 0);
    chk("random progress", (d_done_n > 5 && i_done_n > 5), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Miss handler and memory port owner between the pipelined CPU's instruction/data caches and the multi-cycle main memory. It is the block the fetch and memory stages talk to once the single-cycle memories are replaced by caches. It serialises I-cache block fills, D-cache block fills and D-side write-through stores onto one memory port. Each fill brings one 16-byte block (8 halfwords) into the requesting cache and writes its tag.

## Interface
- MEM_LATENCY, 4, cycles from read issue (mem_en=1, mem_wr=0) to matching mem_rvalid; memory is pipelined, one issue per cycle
- WORDS, 8, halfwords per cache block

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- i_miss  in  1  I-cache fill request; level, held until i_fill_done
- i_miss_addr  in  16  byte address of I miss; bits [3:0] ignored
- d_miss  in  1  D-cache fill request; level, held until d_fill_done
- d_miss_addr  in  16  byte address of D miss; bits [3:0] ignored
- d_wr_req  in  1  write-through store request; level, held until d_wr_done
- d_wr_addr  in  16  store byte address
- d_wr_data  in  16  store data
- mem_en  out  1  memory access this cycle
- mem_wr  out  1  1 = write, 0 = read (valid with mem_en)
- mem_addr  out  16  memory byte address
- mem_wdata  out  16  write data
- mem_rdata  in  16  read data, valid with mem_rvalid
- mem_rvalid  in  1  read data return
- fill_data  out  16  data to cache data array (= mem_rdata)
- fill_word  out  3  halfword offset within block
- i_fill_we  out  1  write fill_data into I-cache at fill_word
- d_fill_we  out  1  write fill_data into D-cache at fill_word
- i_tag_we  out  1  write tag/valid for latched I block
- d_tag_we  out  1  write tag/valid for latched D block
- i_fill_done  out  1  one-cycle pulse, I fill complete
- d_fill_done  out  1  one-cycle pulse, D fill complete
- d_wr_done  out  1  one-cycle pulse, store issued to memory
- busy  out  1  state != IDLE or drain active

## Operation
- States: IDLE, WRITE, FILL.
- IDLE priority when sampling requests: d_wr_req > d_miss > i_miss. On accept, the block latches the address (and data for a store), records the target (I/D), and clears the issue and receive counters.
- WRITE: one cycle. mem_en=1, mem_wr=1, mem_addr/mem_wdata come from the latched values, and d_wr_done=1. Next state is IDLE.
- FILL: base = latched_addr & 16'hFFF0.
  - Issue: issue_cnt runs 0..7. While issue_cnt<8, the block drives mem_en=1, mem_wr=0, mem_addr=base+2*issue_cnt, then increments issue_cnt.
  - Receive: on each mem_rvalid, fill_word=recv_cnt, fill_data=mem_rdata, target fill_we=1, then recv_cnt increments.
  - On the 8th rvalid (recv_cnt==7), the same cycle also asserts target tag_we=1 and target fill_done=1. Next state is IDLE.
- Requests arriving during WRITE/FILL are not lost: requests are level signals, so a held request is resampled in IDLE. IDLE always spends at least one cycle between operations.
- Outside FILL, mem_rvalid is ignored: no fill_we, no counter change.
- The block never issues a write during FILL.
- Drain: rst loads drain_cnt=MEM_LATENCY. While drain_cnt>0, the block stays in IDLE, accepts nothing, keeps busy=1, ignores mem_rvalid, and decrements drain_cnt. This discards returns from reads issued before reset.
- Output reset values:
  - All 1-bit outputs are 0 except busy, which is 1 during drain.
  - mem_addr, mem_wdata, fill_word and the counters are 0.
  - fill_data follows mem_rdata; it is don't-care when no fill_we is asserted.
- Counter widths: issue_cnt is 4 bits (0..8), recv_cnt is 3 bits. Address arithmetic is 16-bit; base+14 never exceeds 16'hFFFE.

## Timing
- Request sampled high in IDLE at cycle t → state change at t+1.
- Store: mem write and d_wr_done at t+1; IDLE at t+2; the next request can be sampled at t+2.
- Fill: issues at t+1..t+8; rvalids at t+1+MEM_LATENCY .. t+8+MEM_LATENCY; done/tag_we at t+12 (default latency); IDLE at t+13. Total 12 cycles in FILL.
- Simultaneous d_miss and i_miss at t: D fill done at t+12; I accepted at t+13; I fill done at t+25.
- rst asserted mid-FILL: next cycle is IDLE with counters 0, no done or tag_we pulse, and drain for MEM_LATENCY cycles. The requester must keep its request held; the fill restarts from word 0 after drain.
- Combinational: fill_we, tag_we and done pulses are asserted in the same cycle as mem_rvalid. mem_* outputs are driven from registered state.

## Test plan
- Reset: rst high for 2 cycles, then low → all outputs 0, busy=1 for 4 cycles then 0; the first request is accepted only after drain.
- D fill at d_miss_addr=16'h1236 with memory returning addr^16'hA5A5 → mem_addr 1230,1232,…,123E on consecutive cycles; d_fill_we ×8 with fill_word 0..7 and matching data; d_tag_we and d_fill_done together on the 8th, 12 cycles after entry; no i_* activity.
- d_wr_req (addr 16'h0040, data 16'hBEEF) together with i_miss → a write cycle (mem_wr=1, 0040, BEEF) with d_wr_done, one IDLE cycle, then I fill; i_fill_done 14 cycles after the request.
- d_miss and i_miss together, base 16'hFFF0 for I → D fill completes first; I fill addresses FFF0..FFFE with no wrap; i_fill_done 25 cycles after the requests.
- Spurious mem_rvalid while in IDLE → no fill_we, no counter change; the next fill still writes fill_word 0..7.
- rst pulsed after 3 rvalids of a D fill → no d_tag_we or d_fill_done; the 4 stale rvalids are ignored; with d_miss still held, the fill restarts at base word 0 and completes normally.
